// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jk_pkg
// Brief    : Shared types and excitation rule for the JK bank driver.
//            Macro JK_TOGGLE_EN selects toggle (J=K=1) excitation for changes.
// Revision : 1.0
// ============================================================================
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Three bits cover the full 0..7 retry range.
    localparam int c_retry_w = 3;

    // Returns {J, K} for one cell; applied bit by bit so it works at any width.
    function automatic logic [1:0] jk_excite_bit(input logic q, input logic t);
`ifdef JK_TOGGLE_EN
        return {q ^ t, q ^ t};
`else
        return {~q & t, q & ~t};
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/jk_excite.sv
`default_nettype none
// ============================================================================
// Module   : jk_excite
// Brief    : Combinational J/K excitation from current Q toward a target word.
//            Macro JK_TOGGLE_EN selects the toggle variant.
// Revision : 1.0
// ============================================================================
module jk_excite
    import jk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [1:0] w_jk;
        assign w_jk  = jk_excite_bit(q[gi], target[gi]);
        assign j[gi] = w_jk[1];
        assign k[gi] = w_jk[0];
    end

endmodule
`default_nettype wire

// File: rtl/jk_bank_driver.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_driver
// Brief    : Drives an external JK flip-flop bank to a requested word, checks
//            the result and retries; JK_TOGGLE_EN selects toggle excitation.
// Revision : 1.0
// ============================================================================
module jk_bank_driver
    import jk_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    input  logic [WIDTH-1:0] q_in,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [c_retry_w-1:0] c_max_retry = c_retry_w'(MAX_RETRY);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH-1:0]       r_target;
    logic [c_retry_w-1:0]   r_retry;
    logic [WIDTH-1:0]       w_exc_target;
    logic [WIDTH-1:0]       w_j;
    logic [WIDTH-1:0]       w_k;
    logic                   w_match;

    assign w_match      = (q_in == r_target);
    // On accept the target register is not loaded yet, so excite from in_data.
    assign w_exc_target = (r_state == IDLE) ? in_data : r_target;

    jk_excite #(
        .WIDTH (WIDTH)
    ) u_excite (
        .q      (q_in),
        .target (w_exc_target),
        .j      (w_j),
        .k      (w_k)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = DRIVE;
            DRIVE:   w_state_nxt = CHECK;
            CHECK:   w_state_nxt = (w_match || (r_retry == c_max_retry)) ? IDLE : DRIVE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state == DRIVE) || (r_state == CHECK);
        in_ready = (r_state == IDLE);
    end

    // Drive registers default to zero so they clear on the edge leaving DRIVE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target <= '0;
            r_retry  <= '0;
            j_out    <= '0;
            k_out    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            j_out <= '0;
            k_out <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_target <= in_data;
                        r_retry  <= '0;
                        j_out    <= w_j;
                        k_out    <= w_k;
                    end
                end
                CHECK: begin
                    if (w_match) begin
                        done <= 1'b1;
                    end else if (r_retry == c_max_retry) begin
                        err <= 1'b1;
                    end else begin
                        r_retry <= r_retry + c_retry_w'(1);
                        j_out   <= w_j;
                        k_out   <= w_k;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_bank_driver
// Brief    : Self-checking bench with a JK bank model in the feedback loop.
// Revision : 1.0
// ============================================================================
module tb_jk_bank_driver;

    localparam int WIDTH     = 4;
    localparam int MAX_RETRY = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [WIDTH-1:0] j_out;
    logic [WIDTH-1:0] k_out;
    logic [WIDTH-1:0] q_in;
    logic             busy;
    logic             done;
    logic             err;

    logic [WIDTH-1:0] bank_q;
    logic [WIDTH-1:0] stuck_mask = '0;
    logic [WIDTH-1:0] load_val = '0;
    logic             load = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] e_j [8];
    logic [WIDTH-1:0] e_k [8];
    logic [WIDTH-1:0] e_q;
    int               e_passes;
    logic             e_ok;

    typedef struct {
        logic [WIDTH-1:0] q0;
        logic [WIDTH-1:0] t;
        logic [WIDTH-1:0] stuck;
        logic [WIDTH-1:0] j;
        logic [WIDTH-1:0] k;
        logic [WIDTH-1:0] q;
        logic             ok;
        int               passes;
    } vec_t;

    vec_t tbl [5];

    always #5 clk = ~clk;

    jk_bank_driver #(
        .WIDTH     (WIDTH),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .j_out    (j_out),
        .k_out    (k_out),
        .q_in     (q_in),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // External JK bank: hold / reset / set / toggle per cell.
    always @(posedge clk) begin
        if (load) begin
            bank_q <= load_val;
        end else begin
            for (int b = 0; b < WIDTH; b++) begin
                case ({j_out[b], k_out[b]})
                    2'b10:   bank_q[b] <= 1'b1;
                    2'b01:   bank_q[b] <= 1'b0;
                    2'b11:   bank_q[b] <= ~bank_q[b];
                    default: ;
                endcase
            end
        end
    end

    assign q_in = bank_q & ~stuck_mask;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_w(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Reference: iterate drive passes on a plain Q value until the observed
    // word matches or the retry budget is spent.
    task automatic model(input logic [WIDTH-1:0] q0, input logic [WIDTH-1:0] t,
                         input logic [WIDTH-1:0] stuck);
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] obs;
        logic [WIDTH-1:0] jj;
        logic [WIDTH-1:0] kk;
        q        = q0;
        e_ok     = 1'b0;
        e_passes = MAX_RETRY + 1;
        for (int p = 0; p <= MAX_RETRY; p++) begin
            obs = q & ~stuck;
`ifdef JK_TOGGLE_EN
            jj = obs ^ t;
            kk = obs ^ t;
`else
            jj = ~obs & t;
            kk = obs & ~t;
`endif
            e_j[p] = jj;
            e_k[p] = kk;
            for (int b = 0; b < WIDTH; b++) begin
                if (jj[b] && kk[b])  q[b] = ~q[b];
                else if (jj[b])      q[b] = 1'b1;
                else if (kk[b])      q[b] = 1'b0;
            end
            if ((q & ~stuck) == t) begin
                e_ok     = 1'b1;
                e_passes = p + 1;
                break;
            end
        end
        e_q = q & ~stuck;
    endtask

    task automatic prep(input logic [WIDTH-1:0] q0, input logic [WIDTH-1:0] stuck);
        @(negedge clk);
        load       = 1'b1;
        load_val   = q0;
        stuck_mask = stuck;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Issues one request at a negedge with the DUT idle and follows it to its pulse.
    task automatic run_req(input string name, input logic [WIDTH-1:0] t);
        int cyc;
        int p;
        bit seen;
        in_data  = t;
        in_valid = 1'b1;
        chk_b({name, " ready"}, in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        cyc  = 1;
        seen = 0;
        while (cyc <= 40 && !seen) begin
            if (done || err) begin
                seen = 1;
                chk_b({name, " done"}, done, e_ok);
                chk_b({name, " err"}, err, ~e_ok);
                chk_i({name, " latency"}, cyc, 1 + 2 * e_passes);
                chk_w({name, " final q"}, q_in, e_q);
                chk_b({name, " busy at pulse"}, busy, 1'b0);
            end else begin
                chk_b({name, " busy"}, busy, 1'b1);
                if (cyc % 2 == 1) begin
                    p = (cyc - 1) / 2;
                    if (p <= MAX_RETRY) begin
                        chk_w({name, " j"}, j_out, e_j[p]);
                        chk_w({name, " k"}, k_out, e_k[p]);
                    end
                end else begin
                    chk_w({name, " j idle in check"}, j_out, '0);
                    chk_w({name, " k idle in check"}, k_out, '0);
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s timeout: got no done/err want pulse", name);
        end
    endtask

    initial begin
        int  cyc;
        bit  flag;
        logic [WIDTH-1:0] rq;
        logic [WIDTH-1:0] rt;
        logic [WIDTH-1:0] rs;

`ifdef JK_TOGGLE_EN
        tbl[0] = '{4'b0000, 4'b1010, 4'b0000, 4'b1010, 4'b1010, 4'b1010, 1'b1, 1};
        tbl[1] = '{4'b1100, 4'b0110, 4'b0000, 4'b1010, 4'b1010, 4'b0110, 1'b1, 1};
        tbl[2] = '{4'b0101, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 1'b1, 1};
        tbl[3] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0, 3};
        tbl[4] = '{4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 1'b1, 1};
`else
        tbl[0] = '{4'b0000, 4'b1010, 4'b0000, 4'b1010, 4'b0000, 4'b1010, 1'b1, 1};
        tbl[1] = '{4'b1100, 4'b0110, 4'b0000, 4'b0010, 4'b1000, 4'b0110, 1'b1, 1};
        tbl[2] = '{4'b0101, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 1'b1, 1};
        tbl[3] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0, 3};
        tbl[4] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b1, 1};
`endif

        load     = 1'b1;
        load_val = '0;
        repeat (3) @(negedge clk);
        chk_w("reset j_out", j_out, '0);
        chk_w("reset k_out", k_out, '0);
        chk_b("reset busy", busy, 1'b0);
        chk_b("reset done", done, 1'b0);
        chk_b("reset err", err, 1'b0);
        load  = 1'b0;
        rst_n = 1'b1;
        #1;
        chk_b("in_ready after reset", in_ready, 1'b1);

        // Directed table
        for (int i = 0; i < 5; i++) begin
            prep(tbl[i].q0, tbl[i].stuck);
            for (int p = 0; p < 8; p++) begin
                e_j[p] = tbl[i].j;
                e_k[p] = tbl[i].k;
            end
            e_q      = tbl[i].q;
            e_ok     = tbl[i].ok;
            e_passes = tbl[i].passes;
            run_req($sformatf("tbl%0d", i), tbl[i].t);
        end

        // Held in_valid while busy is ignored; back-to-back accept in done cycle
        prep(4'b0000, 4'b0000);
        in_data  = 4'b1010;
        in_valid = 1'b1;
        @(negedge clk);
        in_data = 4'b1111;
        cyc  = 1;
        flag = 1'b1;
        while (cyc <= 20 && !done && !err) begin
            if (in_ready) flag = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk_b("hold not accepted while busy", flag, 1'b1);
        chk_b("hold done", done, 1'b1);
        chk_i("hold latency", cyc, 3);
        chk_w("hold q", q_in, 4'b1010);
        chk_b("ready in done cycle", in_ready, 1'b1);
        in_data = 4'b0011;
        @(negedge clk);
        in_valid = 1'b0;
        chk_b("b2b busy", busy, 1'b1);
`ifdef JK_TOGGLE_EN
        chk_w("b2b j", j_out, 4'b1001);
        chk_w("b2b k", k_out, 4'b1001);
`else
        chk_w("b2b j", j_out, 4'b0001);
        chk_w("b2b k", k_out, 4'b1000);
`endif
        cyc = 1;
        while (cyc <= 20 && !done && !err) begin
            @(negedge clk);
            cyc++;
        end
        chk_b("b2b done", done, 1'b1);
        chk_w("b2b q", q_in, 4'b0011);

        // Reset during DRIVE aborts silently
        prep(4'b0000, 4'b0000);
        in_data  = 4'b0110;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk_w("abort drive j", j_out, 4'b0110);
        rst_n = 1'b0;
        #1;
        chk_w("abort j_out", j_out, '0);
        chk_w("abort k_out", k_out, '0);
        chk_b("abort busy", busy, 1'b0);
        chk_b("abort done", done, 1'b0);
        chk_b("abort err", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_b("abort in_ready", in_ready, 1'b1);
        flag = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done || err) flag = 1'b1;
        end
        chk_b("abort no pulse", flag, 1'b0);
        chk_w("abort bank held", q_in, 4'b0000);
        model(4'b0000, 4'b0110, 4'b0000);
        run_req("after abort", 4'b0110);

        // Random requests against the reference model
        for (int n = 0; n < 30; n++) begin
            rq = 4'($urandom);
            rt = 4'($urandom);
            rs = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
            model(rq, rt, rs);
            prep(rq, rs);
            run_req($sformatf("rnd%0d", n), rt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jk_bank_driver.md
Name: jk_bank_driver

Overview:
- Drives a bank of WIDTH external JK flip-flops to a requested target word. It computes the J/K excitation from the bank's current Q.
- After one drive cycle it checks the bank's Q against the target, retries on mismatch and reports done or error.
- It is the controlling end of the JK interface: it produces J/K and reads Q back. It sits between a word-level requester and a JK register bank.

Parameters:
- WIDTH, 4, number of JK cells driven; also the data width.
- MAX_RETRY, 2, re-drive attempts after a failed check before an error is flagged; range 0..7.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, a target word is offered.
- in_ready, output, 1, the block accepts a target this cycle.
- in_data, input, WIDTH, the target Q word.
- j_out, output, WIDTH, J drive to the bank; registered.
- k_out, output, WIDTH, K drive to the bank; registered.
- q_in, input, WIDTH, Q feedback from the bank, sampled synchronously.
- busy, output, 1, high from accept until done or err.
- done, output, 1, one-cycle pulse: bank Q equals the target.
- err, output, 1, one-cycle pulse: retries exhausted with Q not equal to the target.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; j_out=0, k_out=0; busy=0, done=0, err=0; retry count=0; target register=0.
  - in_ready=1 as soon as rst_n is released.
- States: IDLE, DRIVE, CHECK.
- IDLE:
  - in_ready=1, j_out=k_out=0.
  - On in_valid=1 at an edge: latch in_data into target, clear the retry count and go to DRIVE.
  - At that same edge, register j_out/k_out from q_in and in_data.
- Excitation, per bit (default build):
  - J = ~q & t
  - K = q & ~t
  - Bits already equal to the target get J=K=0 (hold).
- DRIVE (exactly 1 cycle):
  - j_out/k_out are held; the bank samples them at the closing edge.
  - Next state is CHECK; j_out/k_out clear to 0 at that edge.
- CHECK (1 cycle): compare q_in to target.
  - Equal: done=1 for the next cycle, go to IDLE.
  - Not equal and retry count < MAX_RETRY: increment the count, register the new excitation from the current q_in, go to DRIVE.
  - Not equal and retry count = MAX_RETRY: err=1 for the next cycle, go to IDLE.
- Latency: a first-try success gives a done pulse 3 cycles after the accept edge (accept edge, DRIVE edge, CHECK edge). Each retry adds 2 cycles.
- busy=1 in DRIVE and CHECK; in_ready=0 there. in_valid outside IDLE is ignored and not queued; the requester holds in_valid until in_ready.
- A target equal to the current Q still runs DRIVE (all zero drive) then CHECK, and yields done.
- done and err are never high together. done/err are high in the cycle after CHECK, with state already IDLE; a new accept in that same cycle is legal.
- Reset mid-operation (rst_n low in DRIVE or CHECK): immediate return to IDLE with all outputs 0. No done/err pulse is emitted for the aborted word.

Optional Feature:
- Macro JK_TOGGLE_EN.
- Defined: a bit needing a change is driven J=K=1 (toggle); bits already equal get J=K=0. The retry path uses the same rule against the fresh q_in.
- Undefined: the set/reset excitation above; J=K=1 is never driven.

Decomposition:
- Package jk_pkg holds:
  - the state enum (IDLE, DRIVE, CHECK) with a 2-bit encoding;
  - a width-generic excitation function returning a {J,K} pair per bit;
  - a retry-count width constant sized for MAX_RETRY.
- One combinational sub-module, jk_excite: inputs q, target (WIDTH each); outputs j, k. It implements the excitation rule, including the JK_TOGGLE_EN variant. The FSM module registers its outputs.

Test Plan:
- The bench includes a behavioural WIDTH-bit JK register model (hold/reset/set/toggle) driven by j_out/k_out, with its Q fed back to q_in.
- Scenario 1: reset, then q=0000, request 1010 → j_out=1010, k_out=0000 in DRIVE; done pulse 3 cycles after accept; q=1010; err never asserted.
- Scenario 2: q=1100, request 0110 → j_out=0010, k_out=1000; done; q=0110. With JK_TOGGLE_EN: j_out=k_out=1010, same final q.
- Scenario 3: q=0101, request 0101 → j_out=k_out=0000 in DRIVE; done after 3 cycles.
- Scenario 4: the bench forces q_in bit0 stuck at 0, request 0001, MAX_RETRY=2 → three DRIVE/CHECK passes; err pulse 7 cycles after accept; done never asserted.
- Scenario 5: in_valid held high during busy with data 1111 → not accepted until in_ready. Back-to-back request 0011 offered in the done cycle → accepted in that cycle.
- Scenario 6: rst_n pulsed low during DRIVE → j_out=k_out=0, busy=0 and in_ready=1 immediately; no done/err pulse; the next request completes normally.
